// File: rtl/instruction_loader.sv
// instruction_loader: assembles an MSB-first byte stream into 32-bit words
// and writes them to consecutive instruction-memory addresses from 0. The
// MIPS core is held in reset for the whole session so it never fetches a
// partially written program.
module instruction_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [ADDR_W:0]   WordCount,
    input  logic              Abort,
    input  logic [7:0]        ByteIn,
    input  logic              ByteValid,
    output logic              ByteReady,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [31:0]       WrData,
    output logic              Busy,
    output logic              CpuHold,
    output logic              Done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

    state_t              state, next_state;
    logic [ADDR_W:0]     target;
    logic [ADDR_W-1:0]   word_cnt;
    logic [1:0]          byte_cnt;
    logic [31:0]         shift;
    logic [31:0]         wr_data_q;
    logic [ADDR_W-1:0]   wr_addr_q;

    logic                start_ok;
    logic                accept;
    logic                last_word;
    logic [ADDR_W:0]     target_clamped;
    logic [31:0]         shift_next;

    assign start_ok       = Start && (WordCount != '0);
    assign accept         = (state == RECV) && ByteValid;
    assign last_word      = ({1'b0, word_cnt} == (target - ONE_W));
    assign target_clamped = (WordCount > DEPTH_W) ? DEPTH_W : WordCount;
    assign shift_next     = {shift[23:0], ByteIn};

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; Abort wins in every non-IDLE state.
    // NOTE: next_state gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_ok) next_state = RECV;
            end
            RECV: begin
                if (Abort)                          next_state = IDLE;
                else if (accept && byte_cnt == 2'd3) next_state = WRITE;
            end
            WRITE: begin
                if (Abort)          next_state = IDLE;
                else if (last_word) next_state = DONE;
                else                next_state = RECV;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Session datapath: target latch, byte/word counters, shift register and
    // the held write address/data that are presented while in WRITE.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            target    <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            shift     <= '0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        target   <= target_clamped;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        shift    <= shift_next;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                    // Capture the finished word only when it will be written.
                    if (next_state == WRITE) begin
                        wr_data_q <= shift_next;
                        wr_addr_q <= word_cnt;
                    end
                end
                WRITE: begin
                    if (!Abort && !last_word) begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Moore outputs decoded from the registered state.
    assign ByteReady = (state == RECV);
    assign WrEn      = (state == WRITE);
    assign Busy      = (state == RECV) || (state == WRITE);
    assign CpuHold   = Busy;
    assign Done      = (state == DONE);
    assign WrAddr    = wr_addr_q;
    assign WrData    = wr_data_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: expected writes are queued as
// stimulus is driven and popped when the DUT strobes WrEn.
module tb_instruction_loader;

    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              Start;
    logic [ADDR_W:0]   WordCount;
    logic              Abort;
    logic [7:0]        ByteIn;
    logic              ByteValid;
    logic              ByteReady;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [31:0]       WrData;
    logic              Busy;
    logic              CpuHold;
    logic              Done;

    int  tests    = 0;
    int  fails    = 0;
    int  done_cnt = 0;
    wr_t sb[$];

    instruction_loader #(.DEPTH(32), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .WordCount(WordCount),
        .Abort(Abort), .ByteIn(ByteIn), .ByteValid(ByteValid),
        .ByteReady(ByteReady), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .Busy(Busy), .CpuHold(CpuHold), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every write strobe must match the oldest expectation.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (Done) done_cnt++;
            if (CpuHold !== Busy) check("cpuhold_eq_busy", 64'(CpuHold), 64'(Busy));
            if (WrEn) begin
                if (sb.size() == 0) begin
                    check("wr_unexpected", 64'(WrAddr), 64'hFFFF);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_addr", 64'(WrAddr), 64'(e.addr));
                    check("wr_data", 64'(WrData), 64'(e.data));
                end
            end
        end
    end

    task automatic do_start(input logic [ADDR_W:0] wc);
        @(posedge Clk); #1;
        Start = 1'b1;
        WordCount = wc;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        ByteIn = b;
        ByteValid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge Clk);
            if (ByteReady) begin
                @(posedge Clk); #1;
                ok = 1'b1;
            end
        end
        if (!ok) check("byte_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
        for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8]);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        ByteValid = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge Clk);
            if (Done) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd1);
        @(posedge Clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        ByteValid = 1'b0;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [6:0] pat;
        logic [7:0] bq [4];
        int idx;

        Reset_n = 1'b0; Start = 1'b0; WordCount = '0; Abort = 1'b0;
        ByteIn = '0; ByteValid = 1'b0;
        #23;
        check("reset_outputs",
              64'({ByteReady, WrEn, WrAddr, WrData, Busy, CpuHold, Done}), 64'd0);
        Reset_n = 1'b1;

        // Two-word load with cycle-exact timing.
        do_start(6'd2);
        fork
            begin
                send_word(5'd0, 32'h2008_0005);
                send_word(5'd1, 32'h8C09_0004);
                ByteValid = 1'b0;
            end
            begin
                for (int c = 1; c <= 12; c++) begin
                    @(negedge Clk);
                    check($sformatf("cpuhold_c%0d", c), 64'(CpuHold), 64'(c <= 10));
                    check($sformatf("done_c%0d", c), 64'(Done), 64'(c == 11));
                end
            end
        join
        check("two_word_done_count", 64'(done_cnt), 64'd1);

        // WordCount = 0 is ignored.
        do_start(6'd0);
        @(negedge Clk);
        check("wc0_busy", 64'(Busy), 64'd0);
        check("wc0_ready", 64'(ByteReady), 64'd0);
        idle_cycles(3);

        // Clamped load: 40 requested, 32 written.
        do_start(6'd40);
        for (int i = 0; i < 32; i++)
            send_word(5'(i), {8'(i), 8'hA5, ~8'(i), 8'h3C});
        d0 = done_cnt;
        wait_done("clamp_done");
        @(negedge Clk);
        check("clamp_idle_busy", 64'(Busy), 64'd0);
        check("clamp_done_count", 64'(done_cnt - d0), 64'd1);

        // Backpressure gaps across one word.
        do_start(6'd1);
        sb.push_back('{addr: 5'd0, data: 32'hDEAD_BEEF});
        pat = 7'b1001011;
        bq[0] = 8'hDE; bq[1] = 8'hAD; bq[2] = 8'hBE; bq[3] = 8'hEF;
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            ByteValid = pat[6-i];
            ByteIn = pat[6-i] ? bq[idx] : 8'hFF;
            @(posedge Clk);
            if (pat[6-i]) idx++;
            #1;
        end
        wait_done("gap_done");

        // Abort after one word plus two bytes.
        d0 = done_cnt;
        do_start(6'd3);
        send_word(5'd0, 32'h1234_5678);
        send_byte(8'h9A);
        send_byte(8'hBC);
        ByteValid = 1'b0;
        Abort = 1'b1;
        @(posedge Clk); #1;
        Abort = 1'b0;
        @(negedge Clk);
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_ready", 64'(ByteReady), 64'd0);
        idle_cycles(4);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        do_start(6'd1);
        send_word(5'd0, 32'hCAFE_F00D);
        wait_done("after_abort_done");

        // Start pulse mid-RECV must not disturb target or counters.
        d0 = done_cnt;
        do_start(6'd2);
        sb.push_back('{addr: 5'd0, data: 32'hA1B2_C3D4});
        sb.push_back('{addr: 5'd1, data: 32'hE5F6_0718});
        send_byte(8'hA1);
        send_byte(8'hB2);
        ByteValid = 1'b0;
        Start = 1'b1;
        WordCount = 6'd1;
        @(posedge Clk); #1;
        Start = 1'b0;
        send_byte(8'hC3); send_byte(8'hD4);
        send_byte(8'hE5); send_byte(8'hF6);
        send_byte(8'h07); send_byte(8'h18);
        wait_done("busy_start_done");
        check("busy_start_done_count", 64'(done_cnt - d0), 64'd1);

        // Reset mid-load, then a fresh one-word load.
        do_start(6'd4);
        send_word(5'd0, 32'h1122_3344);
        send_byte(8'h55);
        send_byte(8'h66);
        ByteValid = 1'b0;
        Reset_n = 1'b0;
        #1;
        check("midreset_outputs",
              64'({ByteReady, WrEn, WrAddr, WrData, Busy, CpuHold, Done}), 64'd0);
        @(posedge Clk); #2;
        Reset_n = 1'b1;
        do_start(6'd1);
        send_word(5'd0, 32'h0BAD_F00D);
        wait_done("after_reset_done");

        idle_cycles(3);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
